// File: rtl/prefetch_queue_if.sv
// Bus bundle of the prefetch queue: imem read port and the decode-side valid/ready handshake.
// master is the prefetch queue side, slave is the imem/decode side.
interface prefetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;

    modport master (
        output imem_req, imem_addr, deq_valid, deq_inst, deq_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, deq_ready
    );

    modport slave (
        input  imem_req, imem_addr, deq_valid, deq_inst, deq_pc,
        output imem_gnt, imem_rvalid, imem_rdata, deq_ready
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: keeps in-order imem reads in flight, buffers {pc, inst} pairs for
// decode, and on a redirect flushes the queue and drops responses to stale requests.
module prefetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h200
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         redirect_i,
    input  logic [31:0]                  redirect_pc_i,
    input  logic                         stall_i,
    prefetch_queue_if.master             bus,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned OutW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PendW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [0:0] StRun   = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [OutW-1:0]  outstanding_q, outstanding_d, out_after_rv;
    logic [OutW-1:0]  discard_q, discard_d;
    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PendW-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pend_pc  [MAX_OUTSTANDING];

    logic run, gnt_acc, enq, deq;

    assign run = (state_q == StRun);

    // Space for every in-flight read is reserved up front, so a response always finds a free slot.
    assign bus.imem_req = rst_ni & run & ~redirect_i & ~stall_i
                        & (32'(outstanding_q) < MAX_OUTSTANDING)
                        & ((32'(count_q) + 32'(outstanding_q)) < DEPTH);
    assign bus.imem_addr = fetch_pc_q;

    assign bus.deq_valid = (count_q != '0);
    assign bus.deq_inst  = bus.deq_valid ? inst_mem[head_q] : 32'h0;
    assign bus.deq_pc    = bus.deq_valid ? pc_mem[head_q]   : 32'h0;
    assign count_o       = count_q;

    assign gnt_acc      = bus.imem_req & bus.imem_gnt;
    assign enq          = run & ~redirect_i & bus.imem_rvalid;
    assign deq          = bus.deq_valid & bus.deq_ready;
    assign out_after_rv = outstanding_q - OutW'(bus.imem_rvalid);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q + CntW'(enq) - CntW'(deq);
        outstanding_d = out_after_rv + OutW'(gnt_acc);
        discard_d     = discard_q;
        head_d        = deq ? head_q + PtrW'(1) : head_q;
        tail_d        = enq ? tail_q + PtrW'(1) : tail_q;
        pend_rd_d     = pend_rd_q;
        pend_wr_d     = pend_wr_q;

        if (gnt_acc) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pend_wr_d  = (pend_wr_q == PendW'(MAX_OUTSTANDING - 1)) ? '0 : pend_wr_q + PendW'(1);
        end
        if (enq) begin
            pend_rd_d = (pend_rd_q == PendW'(MAX_OUTSTANDING - 1)) ? '0 : pend_rd_q + PendW'(1);
        end
        if (!run && bus.imem_rvalid) begin
            discard_d = discard_q - OutW'(1);
        end

        // In DRAIN the discard count is owned by the first redirect; later ones only move the pc.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            pend_rd_d  = '0;
            pend_wr_d  = '0;
            if (run) begin
                discard_d = out_after_rv;
            end
        end

        state_d = (discard_d != '0) ? StDrain : StRun;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StRun;
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            pend_rd_q     <= '0;
            pend_wr_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            pend_rd_q     <= pend_rd_d;
            pend_wr_q     <= pend_wr_d;
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (gnt_acc) begin
            pend_pc[pend_wr_q] <= fetch_pc_q;
        end
        if (enq) begin
            pc_mem[tail_q]   <= pend_pc[pend_rd_q];
            inst_mem[tail_q] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: a DEPTH=4 instance for the main scenarios and a
// DEPTH=8/MAX_OUTSTANDING=4 instance for address and pointer wrap.
module tb_prefetch_queue;
    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic        clk_i;
    logic        rst_ni;
    logic        redirect_a, stall_a, redirect_b, stall_b;
    logic [31:0] redirect_pc_a, redirect_pc_b;
    logic [2:0]  count_a;
    logic [3:0]  count_b;

    bit          gnt_en_a, rv_en_a, gnt_en_b, rv_en_b;
    int          n_gnt_a;
    int          n_vec, n_err;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    prefetch_queue_if bus_a ();
    prefetch_queue_if bus_b ();

    prefetch_queue #(
        .DEPTH          (4),
        .MAX_OUTSTANDING(2),
        .RESET_PC       (32'h200)
    ) dut_a (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .redirect_i   (redirect_a),
        .redirect_pc_i(redirect_pc_a),
        .stall_i      (stall_a),
        .bus          (bus_a),
        .count_o      (count_a)
    );

    prefetch_queue #(
        .DEPTH          (8),
        .MAX_OUTSTANDING(4),
        .RESET_PC       (32'h200)
    ) dut_b (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .redirect_i   (redirect_b),
        .redirect_pc_i(redirect_pc_b),
        .stall_i      (stall_b),
        .bus          (bus_b),
        .count_o      (count_b)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // imem models: in-order responses, rvalid at the earliest one cycle after the grant.
    initial begin
        bus_a.imem_gnt = 1'b0; bus_a.imem_rvalid = 1'b0; bus_a.imem_rdata = 32'h0;
        forever begin
            @(negedge clk_i);
            #1;
            if (!rst_ni) begin
                q_a.delete();
                n_gnt_a = 0;
            end
            bus_a.imem_gnt    = gnt_en_a;
            bus_a.imem_rvalid = rv_en_a && (q_a.size() != 0);
            bus_a.imem_rdata  = bus_a.imem_rvalid ? (q_a[0] ^ KEY) : 32'h0;
            #1;
            if (rst_ni) begin
                if (bus_a.imem_rvalid) void'(q_a.pop_front());
                if (bus_a.imem_req && bus_a.imem_gnt) begin
                    q_a.push_back(bus_a.imem_addr);
                    n_gnt_a++;
                end
            end
        end
    end

    initial begin
        bus_b.imem_gnt = 1'b0; bus_b.imem_rvalid = 1'b0; bus_b.imem_rdata = 32'h0;
        forever begin
            @(negedge clk_i);
            #1;
            if (!rst_ni) q_b.delete();
            bus_b.imem_gnt    = gnt_en_b;
            bus_b.imem_rvalid = rv_en_b && (q_b.size() != 0);
            bus_b.imem_rdata  = bus_b.imem_rvalid ? (q_b[0] ^ KEY) : 32'h0;
            #1;
            if (rst_ni) begin
                if (bus_b.imem_rvalid) void'(q_b.pop_front());
                if (bus_b.imem_req && bus_b.imem_gnt) q_b.push_back(bus_b.imem_addr);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge and let combinational outputs settle.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
        #3;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases on a negedge.
    task automatic reset_dut(input string tag);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #3;
        check_eq({tag, "_count"}, 32'(count_a), 32'd0);
        check_eq({tag, "_valid"}, 32'(bus_a.deq_valid), 32'd0);
        check_eq({tag, "_req"}, 32'(bus_a.imem_req), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic wait_deq_a(input string tag);
        int w = 0;
        while (!bus_a.deq_valid && w < 20) begin
            cyc(1);
            w++;
        end
        check_eq({tag, "_deq_seen"}, 32'(bus_a.deq_valid), 32'd1);
    endtask

    initial begin
        int          w;
        logic [31:0] e;
        n_vec = 0; n_err = 0;
        rst_ni = 1'b0;
        redirect_a = 1'b0; redirect_pc_a = 32'h0; stall_a = 1'b0;
        redirect_b = 1'b0; redirect_pc_b = 32'h0; stall_b = 1'b0;
        bus_a.deq_ready = 1'b0; bus_b.deq_ready = 1'b0;
        gnt_en_a = 1'b0; rv_en_a = 1'b0; gnt_en_b = 1'b0; rv_en_b = 1'b0;

        #3;
        check_eq("rst_valid", 32'(bus_a.deq_valid), 32'd0);
        check_eq("rst_req", 32'(bus_a.imem_req), 32'd0);
        check_eq("rst_count", 32'(count_a), 32'd0);
        check_eq("rst_pc", bus_a.deq_pc, 32'h0);
        check_eq("rst_inst", bus_a.deq_inst, 32'h0);

        // Sequential fetch from RESET_PC at one instruction per cycle.
        gnt_en_a = 1'b1; rv_en_a = 1'b1; bus_a.deq_ready = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        w = 0;
        do begin
            cyc(1);
            w++;
        end while (!bus_a.deq_valid && w < 10);
        check_eq("t1_latency", 32'(w), 32'd2);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc(1);
            e = 32'h200 + 32'(4 * i);
            check_eq("t1_valid", 32'(bus_a.deq_valid), 32'd1);
            check_eq("t1_pc", bus_a.deq_pc, e);
            check_eq("t1_inst", bus_a.deq_inst, e ^ KEY);
        end

        // Decode blocked: queue fills, requests stop, one pop frees exactly one request.
        bus_a.deq_ready = 1'b0;
        reset_dut("t2_rst");
        cyc(8);
        check_eq("t2_grants", 32'(n_gnt_a), 32'd4);
        check_eq("t2_count", 32'(count_a), 32'd4);
        check_eq("t2_req", 32'(bus_a.imem_req), 32'd0);
        check_eq("t2_addr", bus_a.imem_addr, 32'h210);
        check_eq("t2_head", bus_a.deq_pc, 32'h200);
        @(negedge clk_i);
        bus_a.deq_ready = 1'b1;
        @(negedge clk_i);
        bus_a.deq_ready = 1'b0;
        cyc(4);
        check_eq("t2_grants2", 32'(n_gnt_a), 32'd5);
        check_eq("t2_count2", 32'(count_a), 32'd4);
        check_eq("t2_head2", bus_a.deq_pc, 32'h204);
        check_eq("t2_req2", 32'(bus_a.imem_req), 32'd0);

        // Redirect with two reads outstanding: both dropped, RUN -> DRAIN -> RUN.
        rv_en_a = 1'b0; bus_a.deq_ready = 1'b1;
        reset_dut("t3_rst");
        cyc(2);
        check_eq("t3_grants", 32'(n_gnt_a), 32'd2);
        check_eq("t3_req_cap", 32'(bus_a.imem_req), 32'd0);
        @(negedge clk_i);
        redirect_a = 1'b1; redirect_pc_a = 32'h1000;
        @(negedge clk_i);
        redirect_a = 1'b0; rv_en_a = 1'b1;
        #3;
        check_eq("t3_drain", 32'(dut_a.state_q), 32'd1);
        check_eq("t3_count", 32'(count_a), 32'd0);
        cyc(1);
        check_eq("t3_drain2", 32'(dut_a.state_q), 32'd1);
        cyc(1);
        check_eq("t3_run", 32'(dut_a.state_q), 32'd0);
        check_eq("t3_addr", bus_a.imem_addr, 32'h1000);
        check_eq("t3_count2", 32'(count_a), 32'd0);
        wait_deq_a("t3");
        check_eq("t3_pc", bus_a.deq_pc, 32'h1000);
        check_eq("t3_inst", bus_a.deq_inst, 32'h1000 ^ KEY);

        // Redirect coinciding with rvalid, then a second redirect while draining.
        rv_en_a = 1'b0; bus_a.deq_ready = 1'b1;
        reset_dut("t4_rst");
        repeat (3) @(negedge clk_i);
        rv_en_a = 1'b1; redirect_a = 1'b1; redirect_pc_a = 32'h1800;
        @(negedge clk_i);
        rv_en_a = 1'b0; redirect_pc_a = 32'h2000;
        #3;
        check_eq("t4_drain", 32'(dut_a.state_q), 32'd1);
        check_eq("t4_discard", 32'(dut_a.discard_q), 32'd1);
        check_eq("t4_count", 32'(count_a), 32'd0);
        @(negedge clk_i);
        redirect_a = 1'b0; rv_en_a = 1'b1;
        #3;
        check_eq("t4_discard2", 32'(dut_a.discard_q), 32'd1);
        check_eq("t4_addr_drain", bus_a.imem_addr, 32'h2000);
        cyc(1);
        check_eq("t4_run", 32'(dut_a.state_q), 32'd0);
        check_eq("t4_req", 32'(bus_a.imem_req), 32'd1);
        check_eq("t4_addr", bus_a.imem_addr, 32'h2000);
        check_eq("t4_count2", 32'(count_a), 32'd0);
        wait_deq_a("t4");
        check_eq("t4_pc", bus_a.deq_pc, 32'h2000);

        // Stall with two reads in flight: they still land, fetch resumes sequentially.
        rv_en_a = 1'b0; bus_a.deq_ready = 1'b0;
        reset_dut("t5_rst");
        repeat (2) @(negedge clk_i);
        stall_a = 1'b1; rv_en_a = 1'b1;
        #3;
        check_eq("t5_req_stall", 32'(bus_a.imem_req), 32'd0);
        cyc(2);
        check_eq("t5_count", 32'(count_a), 32'd2);
        check_eq("t5_grants", 32'(n_gnt_a), 32'd2);
        check_eq("t5_req_stall2", 32'(bus_a.imem_req), 32'd0);
        check_eq("t5_head", bus_a.deq_pc, 32'h200);
        @(negedge clk_i);
        stall_a = 1'b0;
        #3;
        check_eq("t5_req_resume", 32'(bus_a.imem_req), 32'd1);
        check_eq("t5_addr", bus_a.imem_addr, 32'h208);

        // Wide instance: fetch address wraps through zero, head pointer wraps past DEPTH.
        @(negedge clk_i);
        redirect_b = 1'b1; redirect_pc_b = 32'hFFFF_FFFC;
        @(negedge clk_i);
        redirect_b = 1'b0; gnt_en_b = 1'b1; rv_en_b = 1'b1; bus_b.deq_ready = 1'b1;
        #3;
        check_eq("t6_run", 32'(dut_b.state_q), 32'd0);
        check_eq("t6_addr", bus_b.imem_addr, 32'hFFFF_FFFC);
        w = 0;
        while (!bus_b.deq_valid && w < 20) begin
            cyc(1);
            w++;
        end
        check_eq("t6_deq_seen", 32'(bus_b.deq_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc(1);
            e = 32'hFFFF_FFFC + 32'(4 * i);
            check_eq("t6_valid", 32'(bus_b.deq_valid), 32'd1);
            check_eq("t6_pc", bus_b.deq_pc, e);
            check_eq("t6_inst", bus_b.deq_inst, e ^ KEY);
        end
        check_eq("t6_head", 32'(dut_b.head_q), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
